twiddle_addr_gen: RTL

Twiddle-factor address sequencer for the 512-point radix-2 DIT FFT. It walks every stage and butterfly, and issues sine-LUT addresses to the 512-point sine LUT that sits directly downstream. Each address comes with a one-cycle-delayed tag (stage, butterfly, sin/cos phase) that lines up with the LUT's registered `Dout`, so the butterfly datapath can pair LUT data with the right butterfly. The LUT holds one full sine period over addresses 0..511; the cosine is read as sine at +N/4.

---
 rtl/twiddle_addr_gen.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/twiddle_addr_gen.sv
// Twiddle-factor LUT address sequencer for a radix-2 DIT FFT.
// Optional macro TWIDDLE_COS_EN: issue a cosine lookup after each sine.
module twiddle_addr_gen #(
  parameter int N_LOG2 = 9,
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              is_cos,
  output logic              busy,
  output logic              done,
  output logic              tag_valid,
  output logic              tag_is_cos,
  output logic [3:0]        tag_stage,
  output logic [N_LOG2-2:0] tag_bfly
);

  localparam int BW = N_LOG2 - 1;

  localparam logic [3:0] S_LAST =
    4'(N_LOG2 - 1);

  localparam logic [BW-1:0] B_LAST = '1;

  localparam logic [N_LOG2-1:0] QTR =
    N_LOG2'(1) << (N_LOG2 - 2);

  typedef enum logic [1:0] {
    IDLE,
    SIN,
    COS,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [3:0]    s_q, s_d;
  logic [BW-1:0] b_q, b_d;

  logic          tag_valid_q, tag_valid_d;
  logic          tag_is_cos_q, tag_is_cos_d;
  logic [3:0]    tag_stage_q, tag_stage_d;
  logic [BW-1:0] tag_bfly_q, tag_bfly_d;

  logic              req_v;
  logic              req_cos;
  logic              xfer;
  logic              last;
  logic [N_LOG2-1:0] mask;
  logic [N_LOG2-1:0] j;
  logic [N_LOG2-1:0] k;
  logic [N_LOG2-1:0] k_cos;
  logic [N_LOG2-1:0] req_a;
  logic [3:0]        shamt;

  state_t        adv_state;
  logic [3:0]    adv_s;
  logic [BW-1:0] adv_b;

  // Twiddle index: j = b mod 2^s, k = j << (N_LOG2-1-s).
  always_comb begin
    mask  = N_LOG2'((32'd1 << s_q) - 32'd1);
    j     = {1'b0, b_q} & mask;
    shamt = S_LAST - s_q;
    k     = j << shamt;
    k_cos = k + QTR;
  end

  // Request fields; address forced to 0 when idle.
  always_comb begin
    req_v = (state_q == SIN) ||
            (state_q == COS);
`ifdef TWIDDLE_COS_EN
    req_cos = (state_q == COS);
`else
    req_cos = 1'b0;
`endif
    req_a = req_cos ? k_cos : k;
    xfer  = req_v & addr_ready;
    last  = (s_q == S_LAST) &&
            (b_q == B_LAST);
  end

  // Butterfly/stage advance after the last phase of a butterfly.
  always_comb begin
    adv_state = SIN;
    adv_s     = s_q;
    adv_b     = b_q + BW'(1);
    if (last) begin
      adv_state = FIN;
      adv_s     = '0;
      adv_b     = '0;
    end else if (b_q == B_LAST) begin
      adv_s = s_q + 4'd1;
      adv_b = '0;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SIN;
          s_d     = '0;
          b_d     = '0;
        end
      end
      SIN: begin
        if (xfer) begin
`ifdef TWIDDLE_COS_EN
          state_d = COS;
`else
          state_d = adv_state;
          s_d     = adv_s;
          b_d     = adv_b;
`endif
        end
      end
`ifdef TWIDDLE_COS_EN
      COS: begin
        if (xfer) begin
          state_d = adv_state;
          s_d     = adv_s;
          b_d     = adv_b;
        end
      end
`endif
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
        b_d     = '0;
      end
    endcase
  end

  // Tag follows an accepted request by one cycle, like LUT Dout.
  always_comb begin
    tag_valid_d  = xfer;
    tag_is_cos_d = xfer & req_cos;
    tag_stage_d  = xfer ? s_q : '0;
    tag_bfly_d   = xfer ? b_q : '0;
  end

  // State, counter and tag registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      b_q          <= '0;
      tag_valid_q  <= 1'b0;
      tag_is_cos_q <= 1'b0;
      tag_stage_q  <= '0;
      tag_bfly_q   <= '0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      b_q          <= b_d;
      tag_valid_q  <= tag_valid_d;
      tag_is_cos_q <= tag_is_cos_d;
      tag_stage_q  <= tag_stage_d;
      tag_bfly_q   <= tag_bfly_d;
    end
  end

  // Output drive.
  always_comb begin
    addr       = req_v ? ADDR_W'(req_a) : '0;
    addr_valid = req_v;
    is_cos     = req_cos;
    busy       = req_v;
    done       = (state_q == FIN);
    tag_valid  = tag_valid_q;
    tag_is_cos = tag_is_cos_q;
    tag_stage  = tag_stage_q;
    tag_bfly   = tag_bfly_q;
  end

endmodule
